// File: rtl/ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the RV32I execute stage: bus widths, opcode and
// funct3 encodings (ALU, branch, memory), the zero word, the canonical NOP
// and the state encoding of the iterative shifter.
// No ports (package).
// ---------------------------------------------------------------------------
package ex_stage_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int SHAMT_W = 5;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;
  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Memory access funct3 (passed through to MEM untouched)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Iterative shifter states
  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } sh_state_e;

  // Conditional-branch decision; 010/011 are reserved and never taken.
  function automatic logic branch_taken(input logic [2:0]      f3,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = ($signed(a) <  $signed(b));
      F3_BGE:  taken = ($signed(a) >= $signed(b));
      F3_BLTU: taken = (a <  b);
      F3_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ex_serial_shifter.sv
// ---------------------------------------------------------------------------
// ex_serial_shifter
// Iterative 1-bit-per-cycle shifter. A shift by n>0 is accepted in IDLE,
// walks through n SHIFT cycles and presents its result for one DONE cycle.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   start_i  in   current instruction is a shift
//   amount_i in   shift amount (5 bits)
//   left_i   in   1 = logical left, 0 = right
//   arith_i  in   right shift replicates bit 31
//   operand_i in  value to shift
//   busy_o   out  shift in progress (stall request)
//   done_o   out  result_o is valid this cycle
//   result_o out  shifted value
// ---------------------------------------------------------------------------
module ex_serial_shifter
  import ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [SHAMT_W-1:0] amount_i,
  input  logic               left_i,
  input  logic               arith_i,
  input  logic [XLEN-1:0]    operand_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);

  sh_state_e          state_q, state_d;
  logic [XLEN-1:0]    shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic               left_q,  left_d;
  logic               arith_q, arith_d;

  logic start_nz;
  assign start_nz = start_i && (amount_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SH_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    case (state_q)
      SH_IDLE: begin
        if (start_nz) begin
          shreg_d = operand_i;
          cnt_d   = amount_i;
          left_d  = left_i;
          arith_d = arith_i;
          state_d = SH_SHIFT;
        end
      end
      SH_SHIFT: begin
        if (left_q) begin
          shreg_d = {shreg_q[XLEN-2:0], 1'b0};
        end else begin
          shreg_d = {arith_q & shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 5'd1) begin
          state_d = SH_DONE;
        end
      end
      SH_DONE: begin
        // Instruction is still held in ID/EX this cycle; do not restart.
        state_d = SH_IDLE;
      end
      default: begin
        state_d = SH_IDLE;
      end
    endcase
  end

  // Gating with rst_n drops the stall request the moment reset asserts,
  // even though ID/EX may still present the shift instruction.
  assign busy_o   = rst_n && (((state_q == SH_IDLE) && start_nz) ||
                              (state_q == SH_SHIFT));
  assign done_o   = (state_q == SH_DONE);
  assign result_o = shreg_q;

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage RV32I pipeline. Computes ALU results, branch
// and jump resolution, load/store addresses, and requests a stall while the
// optional iterative shifter is working.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ex_pc/op/funct3/funct7        decoded instruction from ID/EX
//   ex_reg1/ex_reg2/ex_imm        operands
//   ex_wd/ex_wreg                 destination register and write enable
//   wd_o/wreg_o/wdata_o           writeback bundle
//   mem_load_o/mem_store_o/
//   mem_funct3_o/mem_addr_o/
//   mem_data_o                    memory-access bundle
//   branch_flag_o/branch_target_o fetch redirect
//   stall_req_o                   hold IF..EX
// Parameter SERIAL_SHIFT: 1 = iterative shifter (stalls), 0 = barrel shift.
// ---------------------------------------------------------------------------
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [6:0]        ex_op,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_funct7,
  input  logic [XLEN-1:0]   ex_reg1,
  input  logic [XLEN-1:0]   ex_reg2,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              mem_load_o,
  output logic              mem_store_o,
  output logic [2:0]        mem_funct3_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_data_o,
  output logic              branch_flag_o,
  output logic [XLEN-1:0]   branch_target_o,
  output logic              stall_req_o
);

  logic is_op, is_op_imm, is_branch, is_shift;
  logic [XLEN-1:0]    op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               shift_left, shift_arith;
  logic [XLEN-1:0]    shift_res;
  logic               shift_stall;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    pc_plus_imm, pc_plus_4, reg1_plus_imm;

  assign is_op       = (ex_op == OPC_OP);
  assign is_op_imm   = (ex_op == OPC_OP_IMM);
  assign is_branch   = (ex_op == OPC_BRANCH);
  assign op_b        = (is_op || is_branch) ? ex_reg2 : ex_imm;
  assign shamt       = op_b[SHAMT_W-1:0];
  assign is_shift    = (is_op || is_op_imm) &&
                       ((ex_funct3 == F3_SLL) || (ex_funct3 == F3_SRL_SRA));
  assign shift_left  = (ex_funct3 == F3_SLL);
  assign shift_arith = (ex_funct3 == F3_SRL_SRA) && ex_funct7;

  assign pc_plus_imm   = ex_pc + ex_imm;
  assign pc_plus_4     = ex_pc + 32'd4;
  assign reg1_plus_imm = ex_reg1 + ex_imm;

  generate
    if (SERIAL_SHIFT) begin : g_serial
      logic            sh_busy;
      logic            sh_done;
      logic [XLEN-1:0] sh_result;

      ex_serial_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst),
        .start_i   (is_shift),
        .amount_i  (shamt),
        .left_i    (shift_left),
        .arith_i   (shift_arith),
        .operand_i (ex_reg1),
        .busy_o    (sh_busy),
        .done_o    (sh_done),
        .result_o  (sh_result)
      );

      // Outside DONE the only result that ever reaches writeback is the
      // shift-by-zero case, which is reg1 itself.
      assign shift_res   = sh_done ? sh_result : ex_reg1;
      assign shift_stall = sh_busy;
    end else begin : g_barrel
      assign shift_res   = shift_left  ? (ex_reg1 << shamt) :
                           shift_arith ? ($signed(ex_reg1) >>> shamt) :
                                         (ex_reg1 >> shamt);
      assign shift_stall = 1'b0;
    end
  endgenerate

  always_comb begin
    alu_res = ZERO_WORD;
    case (ex_funct3)
      F3_ADD_SUB: alu_res = (is_op && ex_funct7) ? (ex_reg1 - op_b)
                                                 : (ex_reg1 + op_b);
      F3_SLL:     alu_res = shift_res;
      F3_SLT:     alu_res = {31'd0, $signed(ex_reg1) < $signed(op_b)};
      F3_SLTU:    alu_res = {31'd0, ex_reg1 < op_b};
      F3_XOR:     alu_res = ex_reg1 ^ op_b;
      F3_SRL_SRA: alu_res = shift_res;
      F3_OR:      alu_res = ex_reg1 | op_b;
      F3_AND:     alu_res = ex_reg1 & op_b;
      default:    alu_res = ZERO_WORD;
    endcase
  end

  always_comb begin
    wd_o            = '0;
    wreg_o          = 1'b0;
    wdata_o         = ZERO_WORD;
    mem_load_o      = 1'b0;
    mem_store_o     = 1'b0;
    mem_funct3_o    = 3'b000;
    mem_addr_o      = ZERO_WORD;
    mem_data_o      = ZERO_WORD;
    branch_flag_o   = 1'b0;
    branch_target_o = ZERO_WORD;
    case (ex_op)
      OPC_LUI: begin
        wd_o    = ex_wd;
        wreg_o  = ex_wreg;
        wdata_o = ex_imm;
      end
      OPC_AUIPC: begin
        wd_o    = ex_wd;
        wreg_o  = ex_wreg;
        wdata_o = pc_plus_imm;
      end
      OPC_JAL: begin
        wd_o            = ex_wd;
        wreg_o          = ex_wreg;
        wdata_o         = pc_plus_4;
        branch_flag_o   = 1'b1;
        branch_target_o = pc_plus_imm;
      end
      OPC_JALR: begin
        wd_o            = ex_wd;
        wreg_o          = ex_wreg;
        wdata_o         = pc_plus_4;
        branch_flag_o   = 1'b1;
        branch_target_o = reg1_plus_imm & ~32'd1;
      end
      OPC_BRANCH: begin
        wd_o            = ex_wd;
        branch_flag_o   = branch_taken(ex_funct3, ex_reg1, ex_reg2);
        branch_target_o = pc_plus_imm;
      end
      OPC_LOAD: begin
        wd_o         = ex_wd;
        wreg_o       = ex_wreg;
        mem_load_o   = 1'b1;
        mem_funct3_o = ex_funct3;
        mem_addr_o   = reg1_plus_imm;
      end
      OPC_STORE: begin
        wd_o         = ex_wd;
        mem_store_o  = 1'b1;
        mem_funct3_o = ex_funct3;
        mem_addr_o   = reg1_plus_imm;
        mem_data_o   = ex_reg2;
      end
      OPC_OP, OPC_OP_IMM: begin
        wd_o    = ex_wd;
        wreg_o  = ex_wreg;
        wdata_o = alu_res;
      end
      default: ;
    endcase
    // x0 is never written.
    if (wd_o == '0) begin
      wreg_o = 1'b0;
    end
    // Nothing may commit while the shifter holds the pipe.
    if (shift_stall) begin
      wreg_o      = 1'b0;
      mem_load_o  = 1'b0;
      mem_store_o = 1'b0;
    end
  end

  assign stall_req_o = shift_stall;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef logic [140:0] bundle_t;
  typedef struct {
    string   tag;
    bundle_t exp;
    bundle_t mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_pc, ex_reg1, ex_reg2, ex_imm;
  logic [6:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_funct7, ex_wreg;
  logic [4:0]  ex_wd;

  logic [4:0]  wd_o;
  logic        wreg_o, mem_load_o, mem_store_o, branch_flag_o, stall_req_o;
  logic [31:0] wdata_o, mem_addr_o, mem_data_o, branch_target_o;
  logic [2:0]  mem_funct3_o;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  ex_stage #(.SERIAL_SHIFT(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd),
    .ex_wreg(ex_wreg), .ex_imm(ex_imm), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .mem_load_o(mem_load_o), .mem_store_o(mem_store_o),
    .mem_funct3_o(mem_funct3_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .branch_flag_o(branch_flag_o), .branch_target_o(branch_target_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic bundle_t mk(input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata, input logic ld,
                                 input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic bf, input logic [31:0] bt,
                                 input logic stall);
    return {wd, wreg, wdata, ld, st, f3, addr, data, bf, bt, stall};
  endfunction

  function automatic bundle_t observed();
    return {wd_o, wreg_o, wdata_o, mem_load_o, mem_store_o, mem_funct3_o,
            mem_addr_o, mem_data_o, branch_flag_o, branch_target_o, stall_req_o};
  endfunction

  bundle_t full_m, stall_m, stall_only_m;

  task automatic push(input string tag, input bundle_t e, input bundle_t m);
    exp_t x;
    x.tag = tag; x.exp = e; x.mask = m;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    bundle_t obs;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_empty observed=output expected=entry");
    end else begin
      x   = sb.pop_front();
      obs = observed();
      assert ((obs & x.mask) === (x.exp & x.mask)) else begin
        tests_failed++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs & x.mask, x.exp & x.mask);
      end
      $display("[TB] %s obs=%h", x.tag, obs & x.mask);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] wd, input logic wreg);
    @(posedge clk);
    #1;
    ex_op = op; ex_funct3 = f3; ex_funct7 = f7; ex_reg1 = r1; ex_reg2 = r2;
    ex_imm = imm; ex_pc = pc; ex_wd = wd; ex_wreg = wreg;
  endtask

  task automatic step(input string tag, input bundle_t e, input bundle_t m);
    push(tag, e, m);
    @(negedge clk);
    check();
  endtask

  initial begin
    full_m       = '1;
    stall_m      = mk(5'h0, 1'b1, 32'h0, 1'b1, 1'b1, 3'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    stall_only_m = mk(5'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

    rst = 1'b0;
    ex_op = '0; ex_funct3 = '0; ex_funct7 = 1'b0; ex_reg1 = '0; ex_reg2 = '0;
    ex_imm = '0; ex_pc = '0; ex_wd = '0; ex_wreg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", '0, full_m);
    check();
    rst = 1'b1;

    drive(OP, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1);
    step("add", mk(5'd3, 1'b1, 32'd12, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    drive(OP, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1);
    step("sub", mk(5'd3, 1'b1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0), full_m);

    // SRAI by 4: five stall cycles, then the result in DONE.
    drive(OP_IMM, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd7, 1'b1);
    for (int i = 0; i < 5; i++) push($sformatf("srai4_stall%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), stall_m);
    push("srai4_done", mk(5'd7, 1'b1, 32'hF800_0000, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check();
    end

    drive(OP_IMM, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 5'd7, 1'b1);
    step("srai0", mk(5'd7, 1'b1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0), full_m);

    drive(BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5, 1'b1);
    step("blt", mk(5'd5, 1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h120, 0), full_m);
    drive(BRANCH, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5, 1'b1);
    step("bltu", mk(5'd5, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0),
         full_m & ~mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0));

    drive(JALR, 3'b000, 1'b0, 32'h1003, 32'd0, 32'd0, 32'h40, 5'd1, 1'b1);
    step("jalr", mk(5'd1, 1'b1, 32'h44, 0, 0, 0, 0, 0, 1'b1, 32'h1002, 0), full_m);
    drive(JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h200, 5'd1, 1'b1);
    step("jal", mk(5'd1, 1'b1, 32'h204, 0, 0, 0, 0, 0, 1'b1, 32'h1F0, 0), full_m);

    drive(STORE, 3'b010, 1'b0, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 32'd0, 5'd0, 1'b0);
    step("store", mk(5'd0, 1'b0, 0, 1'b0, 1'b1, 3'b010, 32'hFFC, 32'hAB, 0, 0, 0),
         full_m & ~mk(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(LOAD, 3'b100, 1'b0, 32'h2000, 32'h55, 32'd8, 32'd0, 5'd9, 1'b1);
    step("load", mk(5'd9, 1'b1, 0, 1'b1, 1'b0, 3'b100, 32'h2008, 0, 0, 0, 0),
         full_m & ~mk(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0));

    drive(LUI, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd4, 1'b1);
    step("lui", mk(5'd4, 1'b1, 32'h1234_5000, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    drive(AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd4, 1'b1);
    step("auipc", mk(5'd4, 1'b1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    drive(OP_IMM, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd6, 1'b1);
    step("slti", mk(5'd6, 1'b1, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    drive(OP_IMM, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd6, 1'b1);
    step("sltiu", mk(5'd6, 1'b1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    drive(OP, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 1'b1);
    step("wd0_no_write", mk(5'd0, 1'b0, 32'd3, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    drive(7'b1111111, 3'b111, 1'b1, 32'hDEAD_BEEF, 32'h1234, 32'h10, 32'h80, 5'd8, 1'b1);
    step("bubble", '0, full_m);

    // SLLI by 31, reset asserted during the tenth cycle.
    drive(OP_IMM, 3'b001, 1'b0, 32'd1, 32'd0, 32'd31, 32'd0, 5'd2, 1'b1);
    for (int i = 0; i < 9; i++) push($sformatf("slli31_stall%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), stall_m);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check();
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    push("rst_drops_stall", '0, stall_only_m);
    check();
    ex_op = OP_IMM; ex_funct3 = 3'b000; ex_funct7 = 1'b0; ex_reg1 = '0;
    ex_reg2 = '0; ex_imm = '0; ex_pc = '0; ex_wd = '0; ex_wreg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    drive(OP_IMM, 3'b001, 1'b0, 32'h4000_0001, 32'd0, 32'd1, 32'd0, 5'd2, 1'b1);
    for (int i = 0; i < 2; i++) push($sformatf("slli1_stall%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), stall_m);
    push("slli1_done", mk(5'd2, 1'b1, 32'h8000_0002, 0, 0, 0, 0, 0, 0, 0, 0), full_m);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check();
    end
    drive(7'b0000000, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step("idle_after_shift", '0, full_m);

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the registered decode bundle from the ID/EX pipeline register. Produces:
  - the writeback bundle and memory-access bundle for the EX/MEM register;
  - branch resolution for IF and ctrl;
  - a stall request for ctrl.
- ALU, compare and address paths are combinational.
- Shifts use an iterative 1-bit-per-cycle shifter FSM, selected by parameter, to save area.

Parameters:
- SERIAL_SHIFT, 1, 1 = iterative shifter with stall; 0 = combinational barrel shift, never stalls.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- ex_pc  in  32  instruction PC
- ex_op  in  7  opcode
- ex_funct3  in  3  funct3
- ex_funct7  in  1  instruction bit 30 (SUB/SRA select)
- ex_reg1  in  32  rs1 value
- ex_reg2  in  32  rs2 value
- ex_wd  in  5  destination register
- ex_wreg  in  1  write enable
- ex_imm  in  32  sign-extended immediate
- wd_o  out  5  destination register
- wreg_o  out  1  register write enable
- wdata_o  out  32  result
- mem_load_o  out  1  load access
- mem_store_o  out  1  store access
- mem_funct3_o  out  3  access size/sign
- mem_addr_o  out  32  reg1+imm
- mem_data_o  out  32  store data (reg2)
- branch_flag_o  out  1  redirect fetch
- branch_target_o  out  32  redirect PC
- stall_req_o  out  1  hold IF..EX (ctrl asserts stall[3:0])

Behaviour:
- Opcodes:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011.
  - Any other opcode: all outputs zero (bubble).
- Operand B = reg2 for OP and BRANCH, imm otherwise. Arithmetic is mod 2^32; SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
- ALU funct3 decode:
  - 000 ADD, or SUB only when op=OP and funct7=1 (ADDI ignores funct7)
  - 001 SLL
  - 010 SLT
  - 011 SLTU
  - 100 XOR
  - 101 SRL, or SRA when funct7=1
  - 110 OR
  - 111 AND
  - Shift amount = B[4:0].
- Per-opcode results:
  - LUI: wdata = imm.
  - AUIPC: wdata = pc+imm.
  - JAL: wdata = pc+4; branch_flag = 1; target = pc+imm.
  - JALR: wdata = pc+4; target = (reg1+imm) & ~1.
  - BRANCH: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 not taken. Target = pc+imm; wreg_o = 0.
  - LOAD: mem_load = 1; wd/wreg pass through.
  - STORE: mem_store = 1; wreg_o = 0.
- wd_o/wreg_o otherwise pass through. wd_o=0 forces wreg_o=0.
- Non-branch outputs: branch_flag_o = 0, branch_target_o = 0.
- Shifter FSM (SERIAL_SHIFT=1), states IDLE, SHIFT, DONE:
  - IDLE:
    - Shift op with amount n=0 → result = reg1 combinationally, no stall.
    - Shift op with n>0 → stall_req_o = 1. On the clock edge, latch shreg=reg1, cnt=n, direction, arith flag → SHIFT.
  - SHIFT:
    - stall_req_o = 1; each cycle shreg shifts 1 bit (SRA replicates bit 31); cnt--.
    - cnt==1 at the edge → DONE.
  - DONE:
    - stall_req_o = 0; wdata_o = shreg; wd/wreg from inputs (held stable by stall).
    - → IDLE next edge.
  - Latency: shift by n occupies n+2 cycles, with stall_req high for n+1 of them.
  - While stall_req_o=1, wreg_o, mem_load_o and mem_store_o are forced to 0 (defensive; ctrl also bubbles EX/MEM).
  - Shift ops never assert branch_flag, so flush cannot coincide with SHIFT.
- Reset:
  - Asserted at any time, including mid-shift: FSM → IDLE, shreg=0, cnt=0.
  - stall_req_o deasserts asynchronously. Combinational outputs follow inputs (ID/EX holds a NOP while in reset).
- Back-to-back shifts: DONE→IDLE; the next shift is evaluated in IDLE the following cycle.

Decomposition:
- Shared defines header: opcode constants, funct3 ALU/branch/mem encodings, bus widths, Zero_Word, NOP encoding, and FSM state encodings for IDLE/SHIFT/DONE.
- One sub-module: ex_serial_shifter (FSM, shreg, cnt; ports start, amount, left, arith, operand, busy, done, result). The parent holds the ALU/branch/memory mux.

Test Plan:
- ADD/SUB: OP, funct3 000, reg1=5, reg2=7, funct7=0 → wdata 12. funct7=1 → wdata 0xFFFFFFFE, wreg 1, stall 0.
- SRA: OP_IMM, reg1=0x80000000, imm=4, funct7=1 → stall_req high 5 cycles; DONE cycle wdata 0xF8000000. Shift by 0 → wdata 0x80000000, no stall.
- BLT: reg1=0xFFFFFFFF, reg2=1, pc=0x100, imm=0x20 → branch_flag 1, target 0x120, wreg 0. BLTU with the same operands → branch_flag 0.
- JALR: pc=0x40, reg1=0x1003, imm=0 → target 0x1002, wdata 0x44.
- STORE: funct3 010, reg1=0x1000, imm=-4, reg2=0xAB → mem_store 1, addr 0xFFC, data 0xAB, wreg 0.
- Reset mid-shift: SLL by 31 with rst low on cycle 10 → stall_req 0 immediately; next SLL by 1 after release → 2-cycle stall, correct result.
